// File: rtl/arm_code_emitter_pkg.sv
// Shared constants for the ARM code emitter: substitution codes, FSM encoding, default widths.
// Combinational helper only; no storage, no handshake.
package arm_code_emitter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        SUBST_NONE  = 2'd0,
        SUBST_IMM8  = 2'd1,
        SUBST_REG   = 2'd2,
        SUBST_IMM12 = 2'd3
    } subst_e;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_POP_LO = 2'd1,
        ST_POP_HI = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

    // Wide immediates are queued high byte first, so they start at POP_HI.
    function automatic state_e first_state(input subst_e s);
        case (s)
            SUBST_NONE:  return ST_EMIT;
            SUBST_IMM12: return ST_POP_HI;
            default:     return ST_POP_LO;
        endcase
    endfunction

endpackage

// File: rtl/arm_code_emitter_if.sv
// Translator / parameter-queue / code-RAM signal bundle seen by the emitter.
// master = emitter side, slave = translator and memory side.
interface arm_code_emitter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              iter_valid;
    logic [DATA_W-1:0] tpl_word;
    logic [1:0]        tpl_subst;
    logic [7:0]        q_data;
    logic              q_empty;
    logic              q_pop;
    logic              start_load;
    logic [ADDR_W-1:0] start_adr;
    logic              code_wr_en;
    logic [ADDR_W-1:0] code_wr_addr;
    logic [DATA_W-1:0] code_wr_data;
    logic              code_wr_ready;
    logic              waiting;
    logic [CNT_W-1:0]  emitted_count;
    logic              imm_ovf;

    modport master (
        input  iter_valid, tpl_word, tpl_subst, q_data, q_empty,
               start_load, start_adr, code_wr_ready,
        output q_pop, code_wr_en, code_wr_addr, code_wr_data,
               waiting, emitted_count, imm_ovf
    );

    modport slave (
        output iter_valid, tpl_word, tpl_subst, q_data, q_empty,
               start_load, start_adr, code_wr_ready,
        input  q_pop, code_wr_en, code_wr_addr, code_wr_data,
               waiting, emitted_count, imm_ovf
    );
endinterface

// File: rtl/arm_code_emitter_field_merge.sv
// Merges one parameter byte into the held template word according to the substitution code.
// Purely combinational, zero latency; no backpressure.
module arm_field_merge
    import arm_code_emitter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] word_i,
    input  subst_e            subst_i,
    input  logic [7:0]        byte_i,
    input  logic              hi_sel_i,
    output logic [DATA_W-1:0] word_o,
    output logic              ovf_o
);

    always_comb begin
        word_o = word_i;
        ovf_o  = 1'b0;
        case (subst_i)
            SUBST_IMM8: word_o[7:0] = byte_i;
            SUBST_REG:  word_o[15:12] = byte_i[3:0];
            SUBST_IMM12: begin
                // Only 12 immediate bits exist; a non-zero top nibble cannot be encoded.
                if (hi_sel_i) begin
                    word_o[11:8] = byte_i[3:0];
                    ovf_o        = |byte_i[7:4];
                end else begin
                    word_o[7:0] = byte_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_code_emitter.sv
// Assembles template words with queued operand bytes and writes them to the code RAM.
// Latency 1 cycle plus one per popped byte; stalls on empty queue and holds the write until code_wr_ready.
module arm_code_emitter
    import arm_code_emitter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    arm_code_emitter_if.master ce
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q,  hold_d;
    subst_e            subst_q, subst_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ovf_q,   ovf_d;

    logic              pop_state;
    logic              pop_fire;
    logic              accept;
    logic              wr_done;
    logic [DATA_W-1:0] merged_word;
    logic              merged_ovf;

    assign pop_state = (state_q == ST_POP_HI) || (state_q == ST_POP_LO);
    assign pop_fire  = pop_state && !ce.q_empty;
    assign accept    = (state_q == ST_IDLE) && ce.iter_valid;
    assign wr_done   = (state_q == ST_EMIT) && ce.code_wr_ready;

    arm_field_merge #(.DATA_W(DATA_W)) u_merge (
        .word_i   (hold_q),
        .subst_i  (subst_q),
        .byte_i   (ce.q_data),
        .hi_sel_i (state_q == ST_POP_HI),
        .word_o   (merged_word),
        .ovf_o    (merged_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (ce.iter_valid) state_d = first_state(subst_e'(ce.tpl_subst));
            ST_POP_HI: if (!ce.q_empty) state_d = ST_POP_LO;
            ST_POP_LO: if (!ce.q_empty) state_d = ST_EMIT;
            ST_EMIT:   if (ce.code_wr_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pop is suppressed during reset so an aborted word never consumes a byte.
    always_comb begin
        ce.waiting       = (state_q != ST_IDLE);
        ce.q_pop         = pop_fire && !reset;
        ce.code_wr_en    = (state_q == ST_EMIT);
        ce.code_wr_addr  = ptr_q;
        ce.code_wr_data  = hold_q;
        ce.emitted_count = cnt_q;
        ce.imm_ovf       = ovf_q;
    end

    always_comb begin
        hold_d  = hold_q;
        subst_d = subst_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if ((state_q == ST_IDLE) && ce.start_load) ptr_d = ce.start_adr;
        if (accept) begin
            hold_d  = ce.tpl_word;
            subst_d = subst_e'(ce.tpl_subst);
        end
        if (pop_fire) begin
            hold_d = merged_word;
            ovf_d  = ovf_q | merged_ovf;
        end
        if (wr_done) begin
            ptr_d = ptr_q + ADDR_W'(1);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            subst_q <= SUBST_NONE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            subst_q <= subst_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_arm_code_emitter.sv
// Self-checking bench for arm_code_emitter: directed scenarios plus randomized templates vs a word-level model.
module tb_arm_code_emitter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_code_emitter_if #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) bus ();

    arm_code_emitter #(.DATA_W(32), .ADDR_W(10), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Environment: parameter queue and code-RAM model, owned by one process.
    byte unsigned pq[$];
    logic         force_empty = 1'b0;
    logic         ready_ctl   = 1'b1;
    bit           rand_ready  = 1'b0;
    int           pops_total  = 0;
    logic [9:0]   wr_addr_log[$];
    logic [31:0]  wr_data_log[$];

    initial begin
        bit pop_pend;
        bus.q_empty       = 1'b1;
        bus.q_data        = 8'h00;
        bus.code_wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            pop_pend = bus.q_pop && !bus.q_empty;
            if (bus.q_pop) pops_total++;
            if (bus.code_wr_en && bus.code_wr_ready) begin
                wr_addr_log.push_back(bus.code_wr_addr);
                wr_data_log.push_back(bus.code_wr_data);
            end
            @(posedge clk);
            #1;
            if (pop_pend && pq.size() > 0) void'(pq.pop_front());
            bus.code_wr_ready = rand_ready ? 1'($urandom % 2) : ready_ctl;
            bus.q_empty       = force_empty || (pq.size() == 0);
            bus.q_data        = (pq.size() > 0) ? pq[0] : 8'h00;
        end
    end

    // Reference state.
    int exp_ptr   = 0;
    int exp_count = 0;
    bit exp_ovf   = 1'b0;

    function automatic logic [31:0] model_word(input logic [31:0] tpl, input int subst,
                                               input int hi, input int lo);
        logic [31:0] r;
        case (subst)
            1:       r = (tpl & 32'hFFFF_FF00) | 32'(lo);
            2:       r = (tpl & 32'hFFFF_0FFF) | 32'((lo % 16) * 4096);
            3:       r = (tpl & 32'hFFFF_F000) | 32'((hi % 16) * 256 + lo);
            default: r = tpl;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] tpl, input logic [1:0] subst,
                         input bit load, input logic [9:0] adr);
        @(posedge clk); #1;
        bus.iter_valid = 1'b1;
        bus.tpl_word   = tpl;
        bus.tpl_subst  = subst;
        bus.start_load = load;
        bus.start_adr  = adr;
        @(posedge clk); #1;
        bus.iter_valid = 1'b0;
        bus.start_load = 1'b0;
        bus.tpl_word   = $urandom;
        bus.tpl_subst  = 2'($urandom);
        if (load) exp_ptr = int'(adr);
    endtask

    task automatic load_ptr(input logic [9:0] adr);
        @(posedge clk); #1;
        bus.start_load = 1'b1;
        bus.start_adr  = adr;
        @(posedge clk); #1;
        bus.start_load = 1'b0;
        exp_ptr = int'(adr);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.waiting) break;
            cyc++;
        end
        n_checks++;
        if (bus.waiting !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout waiting=%b expected 0 after 300 cycles", bus.waiting);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.waiting, bus.code_wr_en, bus.q_pop, bus.imm_ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl waiting/wr_en/q_pop/ovf=%b expected 0000",
                     {bus.waiting, bus.code_wr_en, bus.q_pop, bus.imm_ovf});
        end
        n_checks++;
        if (bus.code_wr_addr !== 10'h0 || bus.code_wr_data !== 32'h0 || bus.emitted_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data addr=%h data=%h count=%0d expected all zero",
                     bus.code_wr_addr, bus.code_wr_data, bus.emitted_count);
        end
    endtask

    task automatic test_plain();
        int lb = wr_data_log.size();
        int pb = pops_total;
        int cyc;
        ready_ctl = 1'b1;
        load_ptr(10'h010);
        issue(32'hE1A0_0000, 2'd0, 1'b0, 10'h0);
        wait_idle(cyc);
        exp_count++;
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL plain_waiting cycles=%0d expected 1", cyc); end
        n_checks++;
        if (wr_data_log.size() !== lb + 1) begin
            n_fail++; $display("FAIL plain_writes got=%0d expected %0d", wr_data_log.size() - lb, 1);
        end else begin
            n_checks++;
            if (wr_addr_log[lb] !== 10'h010 || wr_data_log[lb] !== 32'hE1A0_0000) begin
                n_fail++;
                $display("FAIL plain_write addr=%h data=%h expected 010/E1A00000", wr_addr_log[lb], wr_data_log[lb]);
            end
        end
        n_checks++;
        if (bus.emitted_count !== 16'd1) begin
            n_fail++; $display("FAIL plain_count got=%0d expected 1", bus.emitted_count);
        end
        n_checks++;
        if (pops_total !== pb) begin n_fail++; $display("FAIL plain_pops got=%0d expected 0", pops_total - pb); end
        exp_ptr = (exp_ptr + 1) % 1024;
    endtask

    task automatic test_imm8_empty();
        int lb = wr_data_log.size();
        int pb = pops_total;
        int cyc;
        pq.push_back(8'h2A);
        force_empty = 1'b1;
        issue(32'hE3A0_0000, 2'd1, 1'b0, 10'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.q_pop !== 1'b0 || bus.waiting !== 1'b1) begin
                n_fail++;
                $display("FAIL imm8_empty_hold cyc%0d q_pop=%b waiting=%b expected 0/1", i, bus.q_pop, bus.waiting);
            end
        end
        force_empty = 1'b0;
        wait_idle(cyc);
        exp_count++;
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL imm8_tail_cycles got=%0d expected 2", cyc); end
        n_checks++;
        if (pops_total !== pb + 1) begin n_fail++; $display("FAIL imm8_pops got=%0d expected 1", pops_total - pb); end
        n_checks++;
        if (wr_data_log.size() !== lb + 1) begin
            n_fail++; $display("FAIL imm8_writes got=%0d expected 1", wr_data_log.size() - lb);
        end else begin
            n_checks++;
            if (wr_data_log[lb] !== 32'hE3A0_002A || wr_addr_log[lb] !== 10'(exp_ptr)) begin
                n_fail++;
                $display("FAIL imm8_write addr=%h data=%h expected %h/E3A0002A", wr_addr_log[lb], wr_data_log[lb], exp_ptr);
            end
        end
        exp_ptr = (exp_ptr + 1) % 1024;
    endtask

    task automatic test_imm12();
        logic [7:0]  his[2]  = '{8'h01, 8'h31};
        logic [7:0]  los[2]  = '{8'h23, 8'h00};
        logic [11:0] imms[2] = '{12'h123, 12'h100};
        logic        ovfs[2] = '{1'b0, 1'b1};
        int cyc;
        for (int t = 0; t < 2; t++) begin
            int lb = wr_data_log.size();
            int pb = pops_total;
            logic [31:0] tpl = $urandom;
            pq.push_back(his[t]);
            pq.push_back(los[t]);
            issue(tpl, 2'd3, 1'b0, 10'h0);
            wait_idle(cyc);
            exp_count++;
            n_checks++;
            if (cyc !== 3) begin n_fail++; $display("FAIL imm12_cycles t%0d got=%0d expected 3", t, cyc); end
            n_checks++;
            if (pops_total !== pb + 2) begin n_fail++; $display("FAIL imm12_pops t%0d got=%0d expected 2", t, pops_total - pb); end
            n_checks++;
            if (wr_data_log.size() !== lb + 1) begin
                n_fail++; $display("FAIL imm12_writes t%0d got=%0d expected 1", t, wr_data_log.size() - lb);
            end else begin
                n_checks++;
                if (wr_data_log[lb][11:0] !== imms[t] || wr_data_log[lb][31:12] !== tpl[31:12]) begin
                    n_fail++;
                    $display("FAIL imm12_word t%0d got=%h expected %h", t, wr_data_log[lb], {tpl[31:12], imms[t]});
                end
            end
            n_checks++;
            if (bus.imm_ovf !== ovfs[t]) begin
                n_fail++; $display("FAIL imm12_ovf t%0d got=%b expected %b", t, bus.imm_ovf, ovfs[t]);
            end
            exp_ptr = (exp_ptr + 1) % 1024;
        end
        exp_ovf = 1'b1;
        issue(32'hE1A0_1002, 2'd0, 1'b0, 10'h0);
        wait_idle(cyc);
        exp_count++;
        exp_ptr = (exp_ptr + 1) % 1024;
        n_checks++;
        if (bus.imm_ovf !== 1'b1) begin n_fail++; $display("FAIL imm12_ovf_sticky got=%b expected 1", bus.imm_ovf); end
    endtask

    task automatic test_backpressure();
        int lb = wr_data_log.size();
        int pb = pops_total;
        int cyc;
        logic [31:0] tpl = $urandom;
        logic [31:0] d0;
        logic [9:0]  a0;
        pq.push_back(8'h07);
        ready_ctl = 1'b0;
        issue(tpl, 2'd2, 1'b0, 10'h0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.code_wr_en) break;
        end
        n_checks++;
        if (bus.code_wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_wr_en_timeout got=%b expected 1", bus.code_wr_en); end
        a0 = bus.code_wr_addr;
        d0 = bus.code_wr_data;
        n_checks++;
        if (d0 !== model_word(tpl, 2, 0, 8'h07) || d0[15:12] !== 4'h7 || a0 !== 10'(exp_ptr)) begin
            n_fail++;
            $display("FAIL bp_word addr=%h data=%h expected %h/%h", a0, d0, exp_ptr, model_word(tpl, 2, 0, 8'h07));
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            // Stray template and pointer load while busy must be ignored.
            bus.iter_valid = (k == 1);
            bus.start_load = (k == 1);
            bus.start_adr  = 10'h155;
            bus.tpl_subst  = 2'd0;
            @(negedge clk);
            n_checks++;
            if (bus.code_wr_en !== 1'b1 || bus.waiting !== 1'b1 || bus.code_wr_addr !== a0 || bus.code_wr_data !== d0) begin
                n_fail++;
                $display("FAIL bp_stable cyc%0d wr_en=%b waiting=%b addr=%h data=%h expected 1/1/%h/%h",
                         k, bus.code_wr_en, bus.waiting, bus.code_wr_addr, bus.code_wr_data, a0, d0);
            end
        end
        ready_ctl = 1'b1;
        wait_idle(cyc);
        exp_count++;
        exp_ptr = (exp_ptr + 1) % 1024;
        n_checks++;
        if (wr_data_log.size() !== lb + 1 || pops_total !== pb + 1) begin
            n_fail++;
            $display("FAIL bp_single writes=%0d pops=%0d expected 1/1", wr_data_log.size() - lb, pops_total - pb);
        end
        // The next write must follow on from the held pointer, not the stray load.
        issue(32'hE1A0_0000, 2'd0, 1'b0, 10'h0);
        wait_idle(cyc);
        exp_count++;
        n_checks++;
        if (wr_addr_log[wr_addr_log.size() - 1] !== 10'(exp_ptr)) begin
            n_fail++;
            $display("FAIL bp_next_addr got=%h expected %h", wr_addr_log[wr_addr_log.size() - 1], exp_ptr);
        end
        exp_ptr = (exp_ptr + 1) % 1024;
    endtask

    task automatic test_wrap();
        int lb = wr_data_log.size();
        int cyc;
        logic [9:0] exp_a[2] = '{10'h3FF, 10'h000};
        load_ptr(10'h3FF);
        for (int t = 0; t < 2; t++) begin
            issue(32'hE1A0_0000 + 32'(t), 2'd0, 1'b0, 10'h0);
            wait_idle(cyc);
            exp_count++;
            n_checks++;
            if (wr_addr_log.size() !== lb + t + 1) begin
                n_fail++; $display("FAIL wrap_writes t%0d got=%0d expected %0d", t, wr_addr_log.size() - lb, t + 1);
            end else begin
                n_checks++;
                if (wr_addr_log[lb + t] !== exp_a[t] || wr_data_log[lb + t] !== 32'hE1A0_0000 + 32'(t)) begin
                    n_fail++;
                    $display("FAIL wrap_addr t%0d addr=%h data=%h expected %h", t, wr_addr_log[lb + t], wr_data_log[lb + t], exp_a[t]);
                end
            end
        end
        exp_ptr = 1;
        n_checks++;
        if (bus.emitted_count !== 16'(exp_count)) begin
            n_fail++; $display("FAIL wrap_count got=%0d expected %0d", bus.emitted_count, exp_count);
        end
    endtask

    task automatic test_midreset();
        int lb = wr_data_log.size();
        int pb = pops_total;
        int cyc;
        pq.push_back(8'h12);
        pq.push_back(8'h34);
        force_empty = 1'b1;
        issue(32'hE3A0_0000, 2'd3, 1'b0, 10'h0);
        @(negedge clk);
        n_checks++;
        if (bus.waiting !== 1'b1 || bus.q_pop !== 1'b0) begin
            n_fail++; $display("FAIL midreset_stall waiting=%b q_pop=%b expected 1/0", bus.waiting, bus.q_pop);
        end
        force_empty = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.q_pop !== 1'b0) begin n_fail++; $display("FAIL midreset_pop_in_reset got=%b expected 0", bus.q_pop); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.waiting, bus.code_wr_en, bus.q_pop, bus.imm_ovf} !== 4'b0000 ||
            bus.code_wr_addr !== 10'h0 || bus.code_wr_data !== 32'h0 || bus.emitted_count !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs wt/en/pop/ovf=%b addr=%h data=%h count=%0d expected all zero",
                     {bus.waiting, bus.code_wr_en, bus.q_pop, bus.imm_ovf}, bus.code_wr_addr, bus.code_wr_data, bus.emitted_count);
        end
        @(negedge clk);
        n_checks++;
        if (pops_total !== pb || wr_data_log.size() !== lb) begin
            n_fail++;
            $display("FAIL midreset_side_effects pops=%0d writes=%0d expected 0/0", pops_total - pb, wr_data_log.size() - lb);
        end
        pq.delete();
        exp_ptr = 0; exp_count = 0; exp_ovf = 1'b0;
        issue(32'hE1A0_0000, 2'd0, 1'b0, 10'h0);
        wait_idle(cyc);
        exp_count++;
        n_checks++;
        if (wr_addr_log[wr_addr_log.size() - 1] !== 10'h000 || bus.emitted_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_after addr=%h count=%0d expected 000/1", wr_addr_log[wr_addr_log.size() - 1], bus.emitted_count);
        end
        exp_ptr = 1;
    endtask

    task automatic test_random();
        int cyc;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int lb = wr_data_log.size();
            int pb = pops_total;
            int subst = int'($urandom % 4);
            int hi = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 16);
            int lo = int'($urandom % 256);
            int npop = (subst == 0) ? 0 : ((subst == 3) ? 2 : 1);
            bit load = (i > 0) && ($urandom % 5 == 0);
            logic [9:0]  adr = 10'($urandom);
            logic [31:0] tpl = $urandom;
            logic [31:0] exp_w;
            if (subst == 3) pq.push_back(8'(hi));
            if (subst != 0) pq.push_back(8'(lo));
            issue(tpl, 2'(subst), load, adr);
            wait_idle(cyc);
            exp_w = model_word(tpl, subst, hi, lo);
            if (subst == 3 && hi > 15) exp_ovf = 1'b1;
            exp_count++;
            n_checks++;
            if (wr_data_log.size() !== lb + 1) begin
                n_fail++; $display("FAIL rand_writes it%0d got=%0d expected 1", i, wr_data_log.size() - lb);
            end else begin
                n_checks++;
                if (wr_addr_log[lb] !== 10'(exp_ptr) || wr_data_log[lb] !== exp_w) begin
                    n_fail++;
                    $display("FAIL rand_write it%0d subst=%0d addr=%h data=%h expected %h/%h",
                             i, subst, wr_addr_log[lb], wr_data_log[lb], exp_ptr, exp_w);
                end
            end
            n_checks++;
            if (pops_total !== pb + npop || bus.imm_ovf !== exp_ovf || bus.emitted_count !== 16'(exp_count)) begin
                n_fail++;
                $display("FAIL rand_state it%0d pops=%0d ovf=%b count=%0d expected %0d/%b/%0d",
                         i, pops_total - pb, bus.imm_ovf, bus.emitted_count, npop, exp_ovf, exp_count);
            end
            exp_ptr = (exp_ptr + 1) % 1024;
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.iter_valid = 1'b0;
        bus.tpl_word   = 32'h0;
        bus.tpl_subst  = 2'd0;
        bus.start_load = 1'b0;
        bus.start_adr  = 10'h0;
        test_reset();
        test_plain();
        test_imm8_empty();
        test_imm12();
        test_backpressure();
        test_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded 500000 time units");
        $fatal(1);
    end

endmodule
